// File: rtl/inv_key_schedule_pkg.sv
// Shared definitions for the decrypt-side AES-128 key schedule: state encoding, Rcon and forward S-box.
package inv_key_schedule_pkg;

    localparam int          NR       = 10;
    localparam int          KEY_W    = 128;
    localparam logic [3:0]  LAST_RND = 4'(NR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD_SUB,
        ST_FWD_XOR,
        ST_PRESENT,
        ST_INV_SUB,
        ST_INV_XOR
    } state_e;

    // Entry 0 is the MSB byte of the concatenation, so SBOX_TBL[x] reads naturally.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Handshake and key bus between the key schedule (slave) and its controller/consumer (master).
interface inv_key_schedule_if
    import inv_key_schedule_pkg::*;
();
    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] round_key_o;
    logic [3:0]       key_round;

    modport master (
        output start, key_in, key_ready,
        input  busy, key_valid, round_key_o, key_round
    );

    modport slave (
        input  start, key_in, key_ready,
        output busy, key_valid, round_key_o, key_round
    );
endinterface

// File: rtl/inv_key_schedule_sbox.sv
// Forward AES S-box, one byte per cycle; purely combinational, no latency, no flow control.
module inv_key_schedule_sbox
    import inv_key_schedule_pkg::*;
(
    input  logic [7:0] in_dat,
    output logic [7:0] out_dat
);
    assign out_dat = SBOX_TBL[in_dat];
endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 decrypt key schedule: expands to round 10, then emits keys 10..0 on a valid/ready port.
// Latency 51 edges from start to first key, 6 edges per later key; a stalled key is held until taken.
module inv_key_schedule
    import inv_key_schedule_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    inv_key_schedule_if.slave ks
);
    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  r_q, r_d;
    logic [3:0]  key_round_q, key_round_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [31:0] sub_q, sub_d;
    logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [31:0] sbox_word;
    logic [7:0]  sbox_in_dat, sbox_out_dat;

    // The inverse step needs SubWord of the previous round's w3, which is w3^w2 of the current key.
    assign sbox_word   = (state_q == ST_INV_SUB) ? (w3_q ^ w2_q) : w3_q;
    assign sbox_in_dat = word_byte(rot_word(sbox_word), cnt_q);

    inv_key_schedule_sbox u_sbox (
        .in_dat  (sbox_in_dat),
        .out_dat (sbox_out_dat)
    );

    assign fwd_w0 = w0_q ^ sub_q ^ {rcon(r_q), 24'h0};
    assign fwd_w1 = w1_q ^ fwd_w0;
    assign fwd_w2 = w2_q ^ fwd_w1;
    assign fwd_w3 = w3_q ^ fwd_w2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ks.start) state_d = ST_FWD_SUB;
            ST_FWD_SUB: if (cnt_q == 2'd3) state_d = ST_FWD_XOR;
            ST_FWD_XOR: state_d = (r_q == LAST_RND) ? ST_PRESENT : ST_FWD_SUB;
            ST_PRESENT: begin
                if (ks.key_ready) begin
                    state_d = (key_round_q == 4'd0) ? ST_IDLE : ST_INV_SUB;
                end
            end
            ST_INV_SUB: if (cnt_q == 2'd3) state_d = ST_INV_XOR;
            ST_INV_XOR: state_d = ST_PRESENT;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ks.busy      = (state_q != ST_IDLE);
        ks.key_valid = (state_q == ST_PRESENT);
    end

    assign ks.round_key_o = {w0_q, w1_q, w2_q, w3_q};
    assign ks.key_round   = key_round_q;

    always_comb begin
        cnt_d       = cnt_q;
        r_d         = r_q;
        key_round_d = key_round_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        w3_d        = w3_q;
        sub_d       = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (ks.start) begin
                    w0_d  = ks.key_in[127:96];
                    w1_d  = ks.key_in[95:64];
                    w2_d  = ks.key_in[63:32];
                    w3_d  = ks.key_in[31:0];
                    r_d   = 4'd1;
                    cnt_d = 2'd0;
                end
            end
            ST_FWD_SUB, ST_INV_SUB: begin
                // cnt wraps back to 0 on the last byte, ready for the next pass
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: sub_d[31:24] = sbox_out_dat;
                    2'd1: sub_d[23:16] = sbox_out_dat;
                    2'd2: sub_d[15:8]  = sbox_out_dat;
                    2'd3: sub_d[7:0]   = sbox_out_dat;
                endcase
            end
            ST_FWD_XOR: begin
                w0_d = fwd_w0;
                w1_d = fwd_w1;
                w2_d = fwd_w2;
                w3_d = fwd_w3;
                if (r_q == LAST_RND) begin
                    key_round_d = LAST_RND;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            ST_INV_XOR: begin
                w3_d        = w3_q ^ w2_q;
                w2_d        = w2_q ^ w1_q;
                w1_d        = w1_q ^ w0_q;
                w0_d        = w0_q ^ sub_q ^ {rcon(key_round_q), 24'h0};
                key_round_d = key_round_q - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            r_q         <= 4'd0;
            key_round_q <= 4'd0;
            w0_q        <= 32'h0;
            w1_q        <= 32'h0;
            w2_q        <= 32'h0;
            w3_q        <= 32'h0;
            sub_q       <= 32'h0;
        end else begin
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            key_round_q <= key_round_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            w3_q        <= w3_d;
            sub_q       <= sub_d;
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: GF(2^8)-derived reference key expansion feeding a queue of expected keys.
module tb_inv_key_schedule;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] JUNK_KEY = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    logic         clk;
    logic         rst;
    int           vectors;
    int           miscompares;
    exp_t         sb_q[$];
    logic [7:0]   sbox_m [256];
    logic [127:0] mdl_rk [11];
    logic [127:0] mdl_key;

    inv_key_schedule_if ks_if();

    inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            b = inv;
            sbox_m[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic void model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        mdl_key = key;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic launch();
        exp_t e;
        ks_if.key_in = mdl_key;
        ks_if.start  = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.key = mdl_rk[r];
            sb_q.push_back(e);
        end
    endtask

    // mode 0: ready held, 1: random ready, 2: 20-cycle stall at round 7,
    // 3: stray start pulses, 4: reset while computing round 4
    task automatic consume_all(input int mode);
        exp_t         e;
        int           gap, exp_gap, stall, guard;
        bit           fresh, holding, rdy;
        logic [127:0] held_key;
        logic [3:0]   held_rnd;
        gap = 0; exp_gap = 51; stall = 0; guard = 0;
        fresh = 1'b1; holding = 1'b0;
        held_key = '0; held_rnd = '0;
        ks_if.key_ready = (mode != 1);
        while (sb_q.size() != 0) begin
            @(negedge clk);
            gap++; guard++;
            ks_if.start = 1'b0;
            if (guard > 3000 || (fresh && gap > 60 && !ks_if.key_valid)) begin
                chk("timeout_key_valid", 128'(ks_if.key_valid), 128'd1);
                sb_q.delete();
                return;
            end
            if (fresh) begin
                if (mode == 1) ks_if.key_ready = 1'($urandom_range(0, 1));
                if (mode == 3 && exp_gap == 51 && gap == 3) begin
                    ks_if.start  = 1'b1;
                    ks_if.key_in = JUNK_KEY;
                end
                if (ks_if.key_valid) begin
                    chk("valid_latency", 128'(gap), 128'(exp_gap));
                    fresh = 1'b0;
                end
            end
            if (!fresh) begin
                chk("valid_held", 128'(ks_if.key_valid), 128'd1);
                if (holding) begin
                    chk("stall_round_key", ks_if.round_key_o, held_key);
                    chk("stall_key_round", 128'(ks_if.key_round), 128'(held_rnd));
                end
                rdy = 1'b1;
                case (mode)
                    1: rdy = 1'($urandom_range(0, 1));
                    2: if (ks_if.key_round == 4'd7 && stall < 20) begin
                           rdy = 1'b0;
                           stall++;
                       end
                    3: if (ks_if.key_round == 4'd10 && !holding) begin
                           rdy = 1'b0;
                           ks_if.start  = 1'b1;
                           ks_if.key_in = JUNK_KEY;
                       end else if (ks_if.key_round == 4'd0) begin
                           ks_if.start  = 1'b1;
                           ks_if.key_in = JUNK_KEY;
                       end
                    default: ;
                endcase
                ks_if.key_ready = rdy;
                if (rdy) begin
                    e = sb_q.pop_front();
                    chk("round_key", ks_if.round_key_o, e.key);
                    chk("key_round", 128'(ks_if.key_round), 128'(e.rnd));
                    fresh = 1'b1; holding = 1'b0; gap = 0; exp_gap = 6;
                    if (e.rnd == 4'd0) begin
                        @(negedge clk);
                        ks_if.start = 1'b0;
                        chk("busy_after_last", 128'(ks_if.busy), 128'd0);
                        chk("valid_after_last", 128'(ks_if.key_valid), 128'd0);
                    end else if (mode == 4 && e.rnd == 4'd5) begin
                        @(negedge clk);
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        chk("abort_busy", 128'(ks_if.busy), 128'd0);
                        chk("abort_valid", 128'(ks_if.key_valid), 128'd0);
                        chk("abort_round_key", ks_if.round_key_o, 128'd0);
                        chk("abort_key_round", 128'(ks_if.key_round), 128'd0);
                        sb_q.delete();
                    end
                end else begin
                    holding  = 1'b1;
                    held_key = ks_if.round_key_o;
                    held_rnd = ks_if.key_round;
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        build_sbox();
        rst             = 1'b1;
        ks_if.start     = 1'b0;
        ks_if.key_in    = '0;
        ks_if.key_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 128'(ks_if.busy), 128'd0);
        chk("reset_valid", 128'(ks_if.key_valid), 128'd0);
        chk("reset_round_key", ks_if.round_key_o, 128'd0);
        chk("reset_key_round", 128'(ks_if.key_round), 128'd0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 128'(ks_if.key_valid), 128'd0);
        end

        model_expand(FIPS_KEY);
        mdl_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        mdl_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        mdl_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        mdl_rk[0]  = FIPS_KEY;
        launch();
        consume_all(0);

        model_expand(FIPS_KEY);
        launch();
        consume_all(2);

        model_expand(FIPS_KEY);
        launch();
        consume_all(3);

        model_expand({$urandom, $urandom, $urandom, $urandom});
        launch();
        consume_all(0);

        model_expand(128'd0);
        launch();
        consume_all(4);

        model_expand(128'd0);
        mdl_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        mdl_rk[1]  = 128'h62636363626363636263636362636363;
        mdl_rk[0]  = 128'd0;
        launch();
        consume_all(0);

        for (int n = 0; n < 200; n++) begin
            model_expand({$urandom, $urandom, $urandom, $urandom});
            launch();
            consume_all(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
